// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//   Conditions the raw left/right/shoot push-button pins before they reach the
//   player logic. Each pin is synchronised (2 flops), then debounced by a small
//   four-state FSM with its own counter. Produces clean levels, a single-cycle
//   fire pulse per press, and auto-repeating left/right step pulses.
//
// Parameters
//   DEBOUNCE_CYCLES  cycles a synchronised pin must stay steady to change level
//   REPEAT_CYCLES    cycles between step pulses while a direction is held
//   CNT_W            counter width, 2**CNT_W > max(DEBOUNCE_CYCLES, REPEAT_CYCLES)
//
// Ports
//   i_clk_36MHz    system clock, rising edge
//   i_reset_n      asynchronous active-low reset
//   i_left/right/shoot   raw asynchronous active-high buttons
//   o_left/right/shoot   debounced levels
//   o_left_step    1-cycle pulse: move left one step (auto-repeats while held)
//   o_right_step   1-cycle pulse: move right one step (auto-repeats while held)
//   o_shoot_pulse  1-cycle pulse once per debounced shoot press
// -----------------------------------------------------------------------------
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 360000,
  parameter int unsigned REPEAT_CYCLES   = 3600000,
  parameter int unsigned CNT_W           = 22
) (
  input  logic i_clk_36MHz,
  input  logic i_reset_n,
  input  logic i_left,
  input  logic i_right,
  input  logic i_shoot,
  output logic o_left,
  output logic o_right,
  output logic o_shoot,
  output logic o_left_step,
  output logic o_right_step,
  output logic o_shoot_pulse
);

  typedef enum logic [1:0] {
    RELEASED   = 2'd0,
    PRESS_PEND = 2'd1,
    HELD       = 2'd2,
    REL_PEND   = 2'd3
  } btn_state_e;

  // Button index: 0 = left, 1 = right, 2 = shoot.
  localparam int NB = 3;
  localparam int ND = 2;

  localparam logic [CNT_W-1:0] ZERO     = '0;
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);

  logic [NB-1:0]    pin;
  logic [NB-1:0]    sync1_q, sync2_q;
  btn_state_e       state_q [NB];
  btn_state_e       state_d [NB];
  logic [CNT_W-1:0] dcnt_q  [NB];
  logic [CNT_W-1:0] dcnt_d  [NB];
  logic [NB-1:0]    level_q, level_d;
  logic [NB-1:0]    rise_d;         // PRESS_PEND -> HELD on this edge
  logic [CNT_W-1:0] rcnt_q  [ND];
  logic [CNT_W-1:0] rcnt_d  [ND];
  logic [ND-1:0]    step_q, step_d;
  logic             shoot_pulse_q;
  logic             conflict;

  assign pin = {i_shoot, i_right, i_left};

  // Debounce FSMs and auto-repeat counters.
  always_comb begin
    for (int b = 0; b < NB; b++) begin
      // NOTE: every combinational output gets a default first so no path
      // through the case statement can leave it unassigned (no latches).
      state_d[b] = state_q[b];
      dcnt_d[b]  = dcnt_q[b];
      rise_d[b]  = 1'b0;
      unique case (state_q[b])
        RELEASED: begin
          if (sync2_q[b]) begin
            state_d[b] = PRESS_PEND;
            dcnt_d[b]  = ZERO;
          end
        end
        PRESS_PEND: begin
          if (!sync2_q[b]) begin
            state_d[b] = RELEASED;
          end else if (dcnt_q[b] == DEB_LAST) begin
            state_d[b] = HELD;
            rise_d[b]  = 1'b1;
          end else begin
            dcnt_d[b] = dcnt_q[b] + ONE;
          end
        end
        HELD: begin
          if (!sync2_q[b]) begin
            state_d[b] = REL_PEND;
            dcnt_d[b]  = ZERO;
          end
        end
        REL_PEND: begin
          if (sync2_q[b]) begin
            state_d[b] = HELD;
          end else if (dcnt_q[b] == DEB_LAST) begin
            state_d[b] = RELEASED;
          end else begin
            dcnt_d[b] = dcnt_q[b] + ONE;
          end
        end
        default: state_d[b] = RELEASED;
      endcase
      level_d[b] = (state_d[b] == HELD) || (state_d[b] == REL_PEND);
    end

    // Repeat counters advance only in HELD; REL_PEND freezes the phase so a
    // short bounce does not shift the step schedule.
    for (int d = 0; d < ND; d++) begin
      rcnt_d[d] = rcnt_q[d];
      step_d[d] = 1'b0;
      if (rise_d[d]) begin
        step_d[d] = 1'b1;
        rcnt_d[d] = ZERO;
      end else if (state_q[d] == HELD) begin
        if (rcnt_q[d] == REP_LAST) begin
          step_d[d] = 1'b1;
          rcnt_d[d] = ZERO;
        end else begin
          rcnt_d[d] = rcnt_q[d] + ONE;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk_36MHz or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      level_q       <= '0;
      step_q        <= '0;
      shoot_pulse_q <= 1'b0;
      // NOTE: the counter arrays are a handful of flops, not a RAM, so they
      // are reset explicitly to give a deterministic restart mid-press.
      for (int b = 0; b < NB; b++) begin
        state_q[b] <= RELEASED;
        dcnt_q[b]  <= ZERO;
      end
      for (int d = 0; d < ND; d++) begin
        rcnt_q[d] <= ZERO;
      end
    end else begin
      sync1_q       <= pin;
      sync2_q       <= sync1_q;
      level_q       <= level_d;
      step_q        <= step_d;
      shoot_pulse_q <= rise_d[2];
      for (int b = 0; b < NB; b++) begin
        state_q[b] <= state_d[b];
        dcnt_q[b]  <= dcnt_d[b];
      end
      for (int d = 0; d < ND; d++) begin
        rcnt_q[d] <= rcnt_d[d];
      end
    end
  end

  // Both directions held: suppress steps; the counters keep running so masked
  // pulses are simply dropped.
  assign conflict      = level_q[0] & level_q[1];
  assign o_left        = level_q[0];
  assign o_right       = level_q[1];
  assign o_shoot       = level_q[2];
  assign o_left_step   = step_q[0] & ~conflict;
  assign o_right_step  = step_q[1] & ~conflict;
  assign o_shoot_pulse = shoot_pulse_q;

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
//   Self-checking bench for button_conditioner with small debounce/repeat
//   constants. A behavioural model tracks, per button, how many consecutive
//   synchronised samples disagree with the current level, and counts held
//   cycles modulo the repeat period; the DUT is compared against it every
//   cycle. Directed scenarios pin the model with hand-computed counts.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

  localparam int D = 4;
  localparam int R = 10;
  localparam int W = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic left  = 1'b0;
  logic right = 1'b0;
  logic shoot = 1'b0;
  logic o_left, o_right, o_shoot, o_left_step, o_right_step, o_shoot_pulse;
  logic [2:0] pins;

  assign pins = {shoot, right, left};

  always #5 clk = ~clk;

  button_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_CYCLES  (R),
    .CNT_W          (W)
  ) dut (
    .i_clk_36MHz  (clk),
    .i_reset_n    (rst_n),
    .i_left       (left),
    .i_right      (right),
    .i_shoot      (shoot),
    .o_left       (o_left),
    .o_right      (o_right),
    .o_shoot      (o_shoot),
    .o_left_step  (o_left_step),
    .o_right_step (o_right_step),
    .o_shoot_pulse(o_shoot_pulse)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Index 0 = left, 1 = right, 2 = shoot.
  int m_sync1 [3];
  int m_sync2 [3];
  int m_level [3];
  int m_streak[3];   // consecutive samples disagreeing with the level
  int m_ticks [3];   // held cycles since the press
  bit m_raw   [3];
  bit m_rose  [3];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 3; b++) begin
        m_sync1[b] = 0; m_sync2[b] = 0; m_level[b] = 0;
        m_streak[b] = 0; m_ticks[b] = 0; m_raw[b] = 0; m_rose[b] = 0;
      end
    end else begin
      for (int b = 0; b < 3; b++) begin
        int s;
        bit was_held;
        s        = m_sync2[b];
        was_held = (m_level[b] == 1) && (m_streak[b] == 0);
        m_rose[b] = 0;
        m_raw[b]  = 0;
        // Level flips on the (D+1)-th consecutive disagreeing sample.
        if (s != m_level[b]) begin
          m_streak[b]++;
          if (m_streak[b] == D + 1) begin
            m_level[b]  = s;
            m_streak[b] = 0;
            m_rose[b]   = (s == 1);
          end
        end else begin
          m_streak[b] = 0;
        end
        if (m_rose[b]) begin
          m_ticks[b] = 0;
          m_raw[b]   = 1;
        end else if (was_held) begin
          m_ticks[b]++;
          if (m_ticks[b] % R == 0) m_raw[b] = 1;
        end
        m_sync2[b] = m_sync1[b];
        m_sync1[b] = int'(pins[b]);
      end
    end
  end

  // ---------------- per-cycle compare + event counters ----------------
  int n_lstep = 0, n_rstep = 0, n_spulse = 0, n_srise = 0, n_sfall = 0;
  int both_fire = 0;
  logic prev_shoot = 1'b0;

  always @(posedge clk) begin
    bit conf;
    #2;
    conf = (m_level[0] == 1) && (m_level[1] == 1);
    check("o_left",        o_left,        32'(m_level[0]));
    check("o_right",       o_right,       32'(m_level[1]));
    check("o_shoot",       o_shoot,       32'(m_level[2]));
    check("o_left_step",   o_left_step,   32'(m_raw[0] && !conf));
    check("o_right_step",  o_right_step,  32'(m_raw[1] && !conf));
    check("o_shoot_pulse", o_shoot_pulse, 32'(m_rose[2]));
    if (o_left_step  === 1'b1) n_lstep++;
    if (o_right_step === 1'b1) n_rstep++;
    if (o_shoot_pulse === 1'b1) n_spulse++;
    if (o_shoot_pulse === 1'b1 && o_left_step === 1'b1) both_fire++;
    if (o_shoot === 1'b1 && prev_shoot === 1'b0) n_srise++;
    if (o_shoot === 1'b0 && prev_shoot === 1'b1) n_sfall++;
    prev_shoot = o_shoot;
  end

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  int lat, s_l, s_r, s_sp, s_sr, s_sf;

  initial begin
    wait_neg(3);
    check("reset_outputs",
          {26'd0, o_left, o_right, o_shoot, o_left_step, o_right_step, o_shoot_pulse}, 32'd0);
    rst_n = 1'b1;

    // 1. Async reset mid-press, then latency from reset release.
    wait_neg(1); left = 1'b1;
    wait_neg(10);
    check("t1_left_before_reset", o_left, 1);
    @(posedge clk); #3 rst_n = 1'b0;
    #1 check("t1_async_reset",
             {26'd0, o_left, o_right, o_shoot, o_left_step, o_right_step, o_shoot_pulse}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk);               // edge k: first sample of the held pin
    lat = 0;
    do begin
      @(posedge clk); #1 lat++;
    end while (o_left !== 1'b1 && lat < 50);
    check("t1_latency", lat, D + 2);
    check("t1_step_at_rise", o_left_step, 1);
    @(negedge clk); left = 1'b0;
    wait_neg(12);

    // 2. Short shoot blip ignored; long press gives one pulse, release latency.
    s_sp = n_spulse; s_sr = n_srise;
    shoot = 1'b1; wait_neg(3); shoot = 1'b0; wait_neg(10);
    check("t2_blip_no_pulse", n_spulse - s_sp, 0);
    check("t2_blip_no_level", n_srise - s_sr, 0);
    shoot = 1'b1; wait_neg(20);
    check("t2_level_high", o_shoot, 1);
    shoot = 1'b0;
    @(posedge clk);               // edge j: first low sample
    lat = 0;
    do begin
      @(posedge clk); #1 lat++;
    end while (o_shoot !== 1'b0 && lat < 50);
    check("t2_release_latency", lat, D + 2);
    check("t2_one_pulse", n_spulse - s_sp, 1);
    wait_neg(10);

    // 3. Right held 30 cycles: steps at rise, +10, +20.
    s_r = n_rstep; s_l = n_lstep;
    right = 1'b1; wait_neg(30); right = 1'b0; wait_neg(15);
    check("t3_right_steps", n_rstep - s_r, 3);
    check("t3_no_left_steps", n_lstep - s_l, 0);

    // 4. Left held, right overlaps: left steps masked during overlap.
    s_r = n_rstep; s_l = n_lstep;
    left = 1'b1; wait_neg(25);
    right = 1'b1; wait_neg(30);
    right = 1'b0; wait_neg(30);
    left = 1'b0; wait_neg(15);
    check("t4_left_steps", n_lstep - s_l, 6);
    check("t4_no_right_steps", n_rstep - s_r, 0);

    // 5. Glitches on held buttons: level kept, no re-fire, repeat phase held.
    s_sp = n_spulse; s_sf = n_sfall;
    shoot = 1'b1; wait_neg(12);
    shoot = 1'b0; wait_neg(2); shoot = 1'b1; wait_neg(12);
    check("t5_shoot_no_drop", n_sfall - s_sf, 0);
    check("t5_shoot_one_pulse", n_spulse - s_sp, 1);
    shoot = 1'b0; wait_neg(12);
    s_l = n_lstep;
    left = 1'b1; wait_neg(20);
    left = 1'b0; wait_neg(2); left = 1'b1; wait_neg(30);
    left = 1'b0; wait_neg(15);
    check("t5_left_steps_phase", n_lstep - s_l, 5);

    // 6. Shoot and left pressed together.
    both_fire = 0;
    shoot = 1'b1; left = 1'b1; wait_neg(12);
    check("t6_same_cycle", both_fire, 1);
    shoot = 1'b0; left = 1'b0; wait_neg(12);

    // Random phase: pins toggle with varying bounce rates, occasional reset.
    for (int i = 0; i < 4000; i++) begin
      int rate;
      @(negedge clk);
      rate = (i / 200) % 2 == 0 ? 3 : 40;
      if ($urandom_range(rate - 1) == 0) left  = ~left;
      if ($urandom_range(rate - 1) == 0) right = ~right;
      if ($urandom_range(rate - 1) == 0) shoot = ~shoot;
      if ($urandom_range(699) == 0) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    left = 1'b0; right = 1'b0; shoot = 1'b0;
    wait_neg(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
